// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if -- signal bundle around the framebuffer RAM arbiter.
//
// Groups the three buses the arbiter sits between:
//   video fetch : vid_req, vid_addr -> vid_dout, vid_valid, vid_overrun
//   CPU bus     : cpu_req, cpu_we, cpu_be, cpu_addr, cpu_din -> cpu_dout, cpu_ack
//   RAM port    : ram_cs, ram_we, ram_be, ram_addr, ram_din <- ram_dout
//   statistics  : stall_clr -> stall_cnt
//
// Modports:
//   slave  -- the arbiter itself (serves video/CPU, drives the RAM)
//   master -- the surrounding system (video timing, CPU decoder, RAM)
// ---------------------------------------------------------------------------
interface vram_arbiter_if;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic [15:0] vid_dout;
    logic        vid_valid;
    logic        vid_overrun;

    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_be;
    logic [13:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_ack;

    logic        ram_cs;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [13:0] ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    logic [15:0] stall_cnt;
    logic        stall_clr;

    modport slave (
        input  vid_req, vid_addr,
        output vid_dout, vid_valid, vid_overrun,
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        output ram_cs, ram_we, ram_be, ram_addr, ram_din,
        input  ram_dout,
        output stall_cnt,
        input  stall_clr
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_dout, vid_valid, vid_overrun,
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        input  ram_cs, ram_we, ram_be, ram_addr, ram_din,
        output ram_dout,
        input  stall_cnt,
        output stall_clr
    );
endinterface

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter -- shares one single-port 16-bit video RAM between the
// scan-out fetch port (strict priority) and the CPU bus.
//
// A slot is IDLE (decide) -> ACCESS (ram_cs high, 1 cycle) -> WAIT
// (RAM_LAT cycles). Read data is captured at the end of the last WAIT cycle
// and vid_valid / cpu_ack pulse in the following IDLE cycle.
//
// Parameters:
//   RAM_LAT  RAM read latency, ram_cs cycle to valid ram_dout (1..4)
// Ports:
//   clk      system/pixel clock
//   reset    asynchronous, active-high
//   bus      vram_arbiter_if.slave (video, CPU, RAM and stats signals)
//
// Build option:
//   VRAM_ARB_STATS_EN  when defined, stall_cnt counts cycles the CPU waits
//                      (cpu_req high, cpu_ack low), saturating, cleared by
//                      stall_clr. When undefined, stall_cnt is tied to 0.
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int RAM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt;
    logic        vid_pend;
    logic        vid_rereq;   // new vid_req landed while a video slot was in flight
    logic        slot_vid;    // current slot belongs to video
    logic        slot_we;     // current slot is a CPU write
    logic [13:0] vid_addr_q;
    logic        grant_vid, grant_cpu, capture;
    logic        cs_nxt, we_nxt;
    logic [1:0]  be_nxt;

    assign grant_vid = (state == IDLE) && (vid_pend || bus.vid_req);
    // cpu_ack high in IDLE means this request was just served; the CPU has
    // not yet had a chance to drop its level request.
    assign grant_cpu = (state == IDLE) && !grant_vid && bus.cpu_req && !bus.cpu_ack;
    assign capture   = (state == WAIT) && (wait_cnt == 3'd0);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == ACCESS)
                wait_cnt <= 3'(RAM_LAT - 1);
            else if (state == WAIT && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vid || grant_cpu) state_nxt = ACCESS;
            ACCESS:  state_nxt = WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM strobes for the coming cycle; registered below so ram_* are flops
    always_comb begin
        cs_nxt = grant_vid || grant_cpu;
        we_nxt = grant_cpu && bus.cpu_we;
        be_nxt = 2'b00;
        if (grant_vid)      be_nxt = 2'b11;
        else if (grant_cpu) be_nxt = bus.cpu_be;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ram_cs      <= 1'b0;
            bus.ram_we      <= 1'b0;
            bus.ram_be      <= 2'b00;
            bus.ram_addr    <= '0;
            bus.ram_din     <= '0;
            bus.vid_dout    <= '0;
            bus.vid_valid   <= 1'b0;
            bus.vid_overrun <= 1'b0;
            bus.cpu_dout    <= '0;
            bus.cpu_ack     <= 1'b0;
            slot_vid        <= 1'b0;
            slot_we         <= 1'b0;
            vid_addr_q      <= '0;
            vid_pend        <= 1'b0;
            vid_rereq       <= 1'b0;
        end else begin
            bus.ram_cs <= cs_nxt;
            bus.ram_we <= we_nxt;
            bus.ram_be <= be_nxt;

            // Same-cycle vid_req supersedes the latched address.
            if (grant_vid) begin
                bus.ram_addr <= bus.vid_req ? bus.vid_addr : vid_addr_q;
            end else if (grant_cpu) begin
                bus.ram_addr <= bus.cpu_addr;
                bus.ram_din  <= bus.cpu_din;
            end

            if (grant_vid || grant_cpu) begin
                slot_vid <= grant_vid;
                slot_we  <= we_nxt;
            end

            if (bus.vid_req)
                vid_addr_q <= bus.vid_addr;
            if (bus.vid_req && vid_pend)
                bus.vid_overrun <= 1'b1;

            bus.vid_valid <= capture && slot_vid;
            bus.cpu_ack   <= capture && !slot_vid;
            if (capture && slot_vid)
                bus.vid_dout <= bus.ram_dout;
            if (capture && !slot_vid && !slot_we)
                bus.cpu_dout <= bus.ram_dout;

            // A request that arrived after this video slot was granted must
            // survive the capture, otherwise the newer address is dropped.
            if (capture && slot_vid) begin
                vid_pend  <= bus.vid_req || vid_rereq;
                vid_rereq <= 1'b0;
            end else begin
                if (bus.vid_req)
                    vid_pend <= 1'b1;
                if (bus.vid_req && state != IDLE && slot_vid)
                    vid_rereq <= 1'b1;
            end
        end
    end

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.stall_cnt <= '0;
        else if (bus.stall_clr)
            bus.stall_cnt <= '0;
        else if (bus.cpu_req && !bus.cpu_ack && bus.stall_cnt != 16'hFFFF)
            bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
`else
    logic unused_stall_clr;
    assign unused_stall_clr = bus.stall_clr;
    assign bus.stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: one instance at RAM_LAT=1, one at
// RAM_LAT=2, each with a small behavioural RAM that drives 0xDEAD whenever
// read data is not valid.
module tb_vram_arbiter;
`ifdef VRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    vram_arbiter_if ia ();
    vram_arbiter_if ib ();

    vram_arbiter #(.RAM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(ia));
    vram_arbiter #(.RAM_LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // preloaded contents for addresses never written
    function automatic logic [15:0] init_val(input logic [13:0] a);
        case (a)
            14'h0123: init_val = 16'hA5A5;
            14'h0010: init_val = 16'h1111;
            14'h0020: init_val = 16'h2222;
            14'h0100: init_val = 16'h0A0A;
            14'h0200: init_val = 16'h0B0B;
            14'h0005: init_val = 16'h5555;
            14'h0006: init_val = 16'h6666;
            default:  init_val = 16'h0000;
        endcase
    endfunction

    // RAM model A (latency 1)
    bit [15:0]   mem_a [16384];
    bit          wr_a  [16384];
    logic [15:0] cur_a;
    assign cur_a = wr_a[ia.ram_addr] ? mem_a[ia.ram_addr] : init_val(ia.ram_addr);
    always @(posedge clk) begin
        if (ia.ram_cs && ia.ram_we) begin
            mem_a[ia.ram_addr] <= {ia.ram_be[1] ? ia.ram_din[15:8] : cur_a[15:8],
                                   ia.ram_be[0] ? ia.ram_din[7:0]  : cur_a[7:0]};
            wr_a[ia.ram_addr]  <= 1'b1;
        end
        ia.ram_dout <= (ia.ram_cs && !ia.ram_we) ? cur_a : 16'hDEAD;
    end

    // RAM model B (latency 2, reads only)
    logic [15:0] stg_b;
    always @(posedge clk) begin
        stg_b       <= (ib.ram_cs && !ib.ram_we) ? init_val(ib.ram_addr) : 16'hDEAD;
        ib.ram_dout <= stg_b;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ia.vid_req = 0; ia.vid_addr = '0; ia.cpu_req = 0; ia.cpu_we = 0;
        ia.cpu_be = 2'b00; ia.cpu_addr = '0; ia.cpu_din = '0; ia.stall_clr = 0;
        ib.vid_req = 0; ib.vid_addr = '0; ib.cpu_req = 0; ib.cpu_we = 0;
        ib.cpu_be = 2'b00; ib.cpu_addr = '0; ib.cpu_din = '0; ib.stall_clr = 0;
        tick(); tick();
        chk("rst_cs",    {15'b0, ia.ram_cs}, 16'h0);
        chk("rst_vdout", ia.vid_dout, 16'h0);
        chk("rst_ack",   {15'b0, ia.cpu_ack}, 16'h0);
        chk("rst_stall", ia.stall_cnt, 16'h0);
        reset = 1'b0;
        tick();

        // lone video fetch, RAM_LAT=1
        ia.vid_req = 1; ia.vid_addr = 14'h0123;
        tick();                                       // c1
        ia.vid_req = 0;
        chk("v1_cs",   {15'b0, ia.ram_cs}, 16'h1);
        chk("v1_addr", {2'b0, ia.ram_addr}, 16'h0123);
        chk("v1_be",   {14'b0, ia.ram_be}, 16'h3);
        tick();                                       // c2
        chk("v1_novld", {15'b0, ia.vid_valid}, 16'h0);
        tick();                                       // c3
        chk("v1_vld",  {15'b0, ia.vid_valid}, 16'h1);
        chk("v1_dout", ia.vid_dout, 16'hA5A5);
        tick();                                       // c4
        chk("v1_vldoff", {15'b0, ia.vid_valid}, 16'h0);
        chk("v1_hold",   ia.vid_dout, 16'hA5A5);

        // CPU write, upper byte, cpu_req held through ack
        ia.cpu_req = 1; ia.cpu_we = 1; ia.cpu_be = 2'b10;
        ia.cpu_addr = 14'h3FFF; ia.cpu_din = 16'hBEEF;
        tick();                                       // c1
        ia.cpu_din = 16'h0000;                        // ignored after grant
        chk("w_cs",   {15'b0, ia.ram_cs}, 16'h1);
        chk("w_we",   {15'b0, ia.ram_we}, 16'h1);
        chk("w_be",   {14'b0, ia.ram_be}, 16'h2);
        chk("w_addr", {2'b0, ia.ram_addr}, 16'h3FFF);
        chk("w_din",  ia.ram_din, 16'hBEEF);
        tick();                                       // c2
        chk("w_cs_off", {15'b0, ia.ram_cs}, 16'h0);
        chk("w_noack",  {15'b0, ia.cpu_ack}, 16'h0);
        tick();                                       // c3
        chk("w_ack",  {15'b0, ia.cpu_ack}, 16'h1);
        chk("w_mem",  mem_a[14'h3FFF], 16'hBE00);
        tick();                                       // c4
        ia.cpu_req = 0; ia.cpu_we = 0;
        chk("w_no2nd",  {15'b0, ia.ram_cs}, 16'h0);
        chk("w_ackoff", {15'b0, ia.cpu_ack}, 16'h0);
        chk("w_cdout",  ia.cpu_dout, 16'h0000);
        chk("w_stall",  ia.stall_cnt, STATS ? 16'd3 : 16'd0);
        ia.stall_clr = 1;
        tick();
        ia.stall_clr = 0;
        chk("clr_stall", ia.stall_cnt, 16'h0);

        // simultaneous video and CPU read: video first
        ia.vid_req = 1; ia.vid_addr = 14'h0010;
        ia.cpu_req = 1; ia.cpu_we = 0; ia.cpu_be = 2'b11; ia.cpu_addr = 14'h0020;
        tick();                                       // c1
        ia.vid_req = 0;
        chk("s_addr_v", {2'b0, ia.ram_addr}, 16'h0010);
        chk("s_we_v",   {15'b0, ia.ram_we}, 16'h0);
        tick(); tick();                               // c3
        chk("s_vld",  {15'b0, ia.vid_valid}, 16'h1);
        chk("s_vdout", ia.vid_dout, 16'h1111);
        tick();                                       // c4
        chk("s_cs_c",   {15'b0, ia.ram_cs}, 16'h1);
        chk("s_addr_c", {2'b0, ia.ram_addr}, 16'h0020);
        tick(); tick();                               // c6
        chk("s_ack",   {15'b0, ia.cpu_ack}, 16'h1);
        chk("s_cdout", ia.cpu_dout, 16'h2222);
        chk("s_stall", ia.stall_cnt, STATS ? 16'd6 : 16'd0);
        tick();                                       // c7
        ia.cpu_req = 0;
        chk("s_ackoff", {15'b0, ia.cpu_ack}, 16'h0);
        chk("s_chold",  ia.cpu_dout, 16'h2222);
        chk("s_noovr",  {15'b0, ia.vid_overrun}, 16'h0);

        // two vid_req pulses 2 cycles apart: overrun, second address fetched
        ia.vid_req = 1; ia.vid_addr = 14'h0100;
        tick();                                       // c1
        ia.vid_req = 0;
        tick();                                       // c2
        ia.vid_req = 1; ia.vid_addr = 14'h0200;
        tick();                                       // c3
        ia.vid_req = 0;
        chk("o_vld1", {15'b0, ia.vid_valid}, 16'h1);
        chk("o_dout1", ia.vid_dout, 16'h0A0A);
        chk("o_ovr",  {15'b0, ia.vid_overrun}, 16'h1);
        tick();                                       // c4
        chk("o_cs2",   {15'b0, ia.ram_cs}, 16'h1);
        chk("o_addr2", {2'b0, ia.ram_addr}, 16'h0200);
        tick(); tick();                               // c6
        chk("o_vld2",  {15'b0, ia.vid_valid}, 16'h1);
        chk("o_dout2", ia.vid_dout, 16'h0B0B);
        tick();                                       // c7
        chk("o_sticky", {15'b0, ia.vid_overrun}, 16'h1);
        chk("o_idle",   {15'b0, ia.ram_cs}, 16'h0);

        // worst case at RAM_LAT=2: CPU granted c0, vid_req c1
        ib.cpu_req = 1; ib.cpu_we = 0; ib.cpu_be = 2'b11; ib.cpu_addr = 14'h0005;
        tick();                                       // c1
        ib.vid_req = 1; ib.vid_addr = 14'h0006;
        chk("l_cs_c",   {15'b0, ib.ram_cs}, 16'h1);
        chk("l_addr_c", {2'b0, ib.ram_addr}, 16'h0005);
        tick();                                       // c2
        ib.vid_req = 0;
        tick();                                       // c3
        chk("l_noack", {15'b0, ib.cpu_ack}, 16'h0);
        tick();                                       // c4
        chk("l_ack",   {15'b0, ib.cpu_ack}, 16'h1);
        chk("l_cdout", ib.cpu_dout, 16'h5555);
        tick();                                       // c5
        ib.cpu_req = 0;
        chk("l_cs_v",   {15'b0, ib.ram_cs}, 16'h1);
        chk("l_addr_v", {2'b0, ib.ram_addr}, 16'h0006);
        tick(); tick();                               // c7
        chk("l_novld", {15'b0, ib.vid_valid}, 16'h0);
        tick();                                       // c8
        chk("l_vld",  {15'b0, ib.vid_valid}, 16'h1);
        chk("l_vdout", ib.vid_dout, 16'h6666);

        // reset in the ACCESS cycle of a CPU write
        ia.cpu_req = 1; ia.cpu_we = 1; ia.cpu_be = 2'b11;
        ia.cpu_addr = 14'h0040; ia.cpu_din = 16'h1234;
        tick();                                       // c1 (ACCESS)
        chk("r_cs_pre", {15'b0, ia.ram_cs}, 16'h1);
        reset = 1'b1;
        ia.cpu_req = 0; ia.cpu_we = 0;
        #1;
        chk("r_cs",    {15'b0, ia.ram_cs}, 16'h0);
        chk("r_we",    {15'b0, ia.ram_we}, 16'h0);
        chk("r_addr",  {2'b0, ia.ram_addr}, 16'h0);
        chk("r_din",   ia.ram_din, 16'h0);
        chk("r_vdout", ia.vid_dout, 16'h0);
        chk("r_cdout", ia.cpu_dout, 16'h0);
        chk("r_ovr",   {15'b0, ia.vid_overrun}, 16'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r_noack", {15'b0, ia.cpu_ack}, 16'h0);
            chk("r_nocs",  {15'b0, ia.ram_cs}, 16'h0);
        end
        chk("r_nowr", {15'b0, wr_a[14'h0040]}, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
